// File: rtl/reg_scoreboard.sv
// Per-GPR scoreboard and issue controller for the decode stage.
// Counts in-flight writes per architectural register, stalls decode on
// RAW hazards or a saturated destination count, and sequences pipeline
// flush (block issue, wait for drain, clear all counts).
module reg_scoreboard #(
   parameter int NUM_REGS   = 32,
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_valid,
   input  logic                  id_rs_en,
   input  logic [REG_ADDR_W-1:0] id_rs_addr,
   input  logic                  id_rt_en,
   input  logic [REG_ADDR_W-1:0] id_rt_addr,
   input  logic                  id_rd_en,
   input  logic [REG_ADDR_W-1:0] id_rd_addr,
   output logic                  id_stall,
   output logic                  id_issue,
   input  logic                  wb_valid,
   input  logic [REG_ADDR_W-1:0] wb_addr,
   input  logic                  flush_req,
   input  logic                  pipe_empty,
   output logic                  flush_done,
   output logic [NUM_REGS-1:0]   busy_vec,
   output logic                  sb_err
);

   typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q [NUM_REGS];
   logic [CNT_W-1:0] cnt_d [NUM_REGS];
   logic             sb_err_q, sb_err_d;
   logic             flush_done_q, flush_done_d;
   logic             clear;
   logic             hazard;
   logic             inc, dec;

   // Hazard check on current (pre-update) counts; register 0 never hazards.
   always_comb begin
      hazard = 1'b0;
      if (id_rs_en && id_rs_addr != '0 && cnt_q[id_rs_addr] != '0) hazard = 1'b1;
      if (id_rt_en && id_rt_addr != '0 && cnt_q[id_rt_addr] != '0) hazard = 1'b1;
      if (id_rd_en && id_rd_addr != '0 && cnt_q[id_rd_addr] == CNT_MAX) hazard = 1'b1;
   end

   assign id_stall = id_valid & (hazard | (state_q == DRAIN) | flush_req);
   assign id_issue = id_valid & ~id_stall;

   assign inc = id_issue & id_rd_en & (id_rd_addr != '0);
   assign dec = wb_valid & (wb_addr != '0) & (cnt_q[wb_addr] != '0);

   // Flush sequencer: RUN -> DRAIN on flush_req, back to RUN (with clear) on pipe_empty.
   always_comb begin
      state_d      = state_q;
      flush_done_d = 1'b0;
      clear        = 1'b0;
      case (state_q)
         RUN: begin
            if (flush_req) state_d = DRAIN;
         end
         DRAIN: begin
            if (pipe_empty) begin
               state_d      = RUN;
               clear        = 1'b1;
               flush_done_d = 1'b1;
            end
         end
         default: state_d = RUN;
      endcase
   end

   // Per-register counter next state; clear wins, inc+dec on one register cancels.
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         cnt_d[i] = cnt_q[i];
         if (i != 0) begin
            if (clear) begin
               cnt_d[i] = '0;
            end else if (inc && (id_rd_addr == REG_ADDR_W'(i)) &&
                         !(dec && (wb_addr == REG_ADDR_W'(i)))) begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (dec && (wb_addr == REG_ADDR_W'(i)) &&
                         !(inc && (id_rd_addr == REG_ADDR_W'(i)))) begin
               cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
         end else begin
            cnt_d[i] = '0;
         end
      end
   end

   // Sticky error on a writeback to a register with nothing pending.
   always_comb begin
      sb_err_d = sb_err_q;
      if (wb_valid && wb_addr != '0 && cnt_q[wb_addr] == '0) sb_err_d = 1'b1;
   end

   // State, counters, error flag and flush pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= RUN;
         sb_err_q     <= 1'b0;
         flush_done_q <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
      end else begin
         state_q      <= state_d;
         sb_err_q     <= sb_err_d;
         flush_done_q <= flush_done_d;
         for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   // Busy hint derived from registered counts; bit 0 is always clear.
   always_comb begin
      busy_vec = '0;
      for (int i = 1; i < NUM_REGS; i++) busy_vec[i] = (cnt_q[i] != '0);
   end

   assign sb_err     = sb_err_q;
   assign flush_done = flush_done_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed testbench for reg_scoreboard with hand-computed expectations.
module tb_reg_scoreboard;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid, id_rs_en, id_rt_en, id_rd_en;
   logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
   logic        id_stall, id_issue;
   logic        wb_valid;
   logic [4:0]  wb_addr;
   logic        flush_req, pipe_empty, flush_done;
   logic [31:0] busy_vec;
   logic        sb_err;

   int n_chk  = 0;
   int n_pass = 0;

   reg_scoreboard #(.NUM_REGS(32), .REG_ADDR_W(5), .CNT_W(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_valid(id_valid),
      .id_rs_en(id_rs_en), .id_rs_addr(id_rs_addr),
      .id_rt_en(id_rt_en), .id_rt_addr(id_rt_addr),
      .id_rd_en(id_rd_en), .id_rd_addr(id_rd_addr),
      .id_stall(id_stall), .id_issue(id_issue),
      .wb_valid(wb_valid), .wb_addr(wb_addr),
      .flush_req(flush_req), .pipe_empty(pipe_empty),
      .flush_done(flush_done), .busy_vec(busy_vec), .sb_err(sb_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_valid = 0; id_rs_en = 0; id_rt_en = 0; id_rd_en = 0;
      id_rs_addr = 0; id_rt_addr = 0; id_rd_addr = 0;
      wb_valid = 0; wb_addr = 0; flush_req = 0; pipe_empty = 0;
   endtask

   task automatic wr(input logic [4:0] rd);
      id_valid = 1; id_rs_en = 0; id_rt_en = 0; id_rd_en = 1; id_rd_addr = rd;
   endtask

   task automatic rdrs(input logic [4:0] rs);
      id_valid = 1; id_rs_en = 1; id_rs_addr = rs; id_rt_en = 0; id_rd_en = 0;
   endtask

   initial begin
      idle();
      rst_n = 0;
      tick(); tick();
      chk("rst_busy", busy_vec, 32'h0);
      chk("rst_err", {31'b0, sb_err}, 32'h0);
      chk("rst_fdone", {31'b0, flush_done}, 32'h0);
      chk("rst_stall", {31'b0, id_stall}, 32'h0);
      rst_n = 1;
      tick();

      // RAW on rd=5
      wr(5); #1;
      chk("t1_issue", {31'b0, id_issue}, 32'h1);
      tick(); idle(); #1;
      chk("t1_busy5", busy_vec, 32'h0000_0020);
      rdrs(5); #1;
      chk("t1_stall", {31'b0, id_stall}, 32'h1);
      chk("t1_noissue", {31'b0, id_issue}, 32'h0);
      wb_valid = 1; wb_addr = 5; #1;
      chk("t1_stall_wb", {31'b0, id_stall}, 32'h1);
      tick(); wb_valid = 0; #1;
      chk("t1_issue_after_wb", {31'b0, id_issue}, 32'h1);
      chk("t1_busy_clr", busy_vec, 32'h0);
      tick(); idle();

      // Register 0 never tracked
      wr(0); #1;
      chk("t2_issue_r0", {31'b0, id_issue}, 32'h1);
      tick(); idle(); #1;
      chk("t2_busy", busy_vec, 32'h0);
      rdrs(0); #1;
      chk("t2_stall_r0", {31'b0, id_stall}, 32'h0);
      tick(); idle();

      // Saturation on rd=7
      for (int k = 0; k < 3; k++) begin
         wr(7); #1;
         chk("t3_issue7", {31'b0, id_issue}, 32'h1);
         tick();
      end
      wr(7); #1;
      chk("t3_sat_stall", {31'b0, id_stall}, 32'h1);
      tick();
      wb_valid = 1; wb_addr = 7; #1;
      chk("t3_sat_stall_wb", {31'b0, id_stall}, 32'h1);
      tick(); #1;                       // cnt7: 3 -> 2
      chk("t3_issue_incdec", {31'b0, id_issue}, 32'h1);
      tick(); wb_valid = 0; #1;         // inc+dec: cnt7 stays 2
      chk("t3_issue_to3", {31'b0, id_issue}, 32'h1);
      tick(); #1;                       // cnt7 -> 3
      chk("t3_sat_again", {31'b0, id_stall}, 32'h1);
      idle(); wb_valid = 1; wb_addr = 7;
      tick(); tick(); #1;
      chk("t3_busy7_after2wb", busy_vec, 32'h0000_0080);
      tick(); wb_valid = 0; #1;
      chk("t3_busy7_after3wb", busy_vec, 32'h0);
      chk("t3_err", {31'b0, sb_err}, 32'h0);

      // Same-cycle inc and dec on rd=9
      wr(9); tick();
      wr(9); wb_valid = 1; wb_addr = 9; #1;
      chk("t4_issue", {31'b0, id_issue}, 32'h1);
      tick(); idle(); #1;
      chk("t4_busy9", busy_vec, 32'h0000_0200);
      wb_valid = 1; wb_addr = 9;
      tick(); wb_valid = 0; #1;
      chk("t4_busy9_clr", busy_vec, 32'h0);
      chk("t4_err", {31'b0, sb_err}, 32'h0);

      // Flush sequence with cnt3=2
      wr(3); tick(); tick(); idle(); #1;
      chk("t5_busy3", busy_vec, 32'h0000_0008);
      wr(4); flush_req = 1; #1;
      chk("t5_stall_freq", {31'b0, id_stall}, 32'h1);
      tick(); flush_req = 0; #1;
      chk("t5_stall_drain", {31'b0, id_stall}, 32'h1);
      chk("t5_fdone0", {31'b0, flush_done}, 32'h0);
      wb_valid = 1; wb_addr = 3; flush_req = 1;   // decrement in DRAIN, flush_req ignored
      tick(); wb_valid = 0; flush_req = 0; #1;
      chk("t5_busy3_drain", busy_vec, 32'h0000_0008);
      chk("t5_stall_drain2", {31'b0, id_stall}, 32'h1);
      tick(); #1;
      chk("t5_still_drain", {31'b0, id_stall}, 32'h1);
      pipe_empty = 1; #1;
      chk("t5_stall_clrcyc", {31'b0, id_stall}, 32'h1);
      tick(); pipe_empty = 0; #1;
      chk("t5_fdone1", {31'b0, flush_done}, 32'h1);
      chk("t5_busy_clr", busy_vec, 32'h0);
      chk("t5_issue_resume", {31'b0, id_issue}, 32'h1);
      tick(); idle(); #1;
      chk("t5_fdone_pulse", {31'b0, flush_done}, 32'h0);
      chk("t5_busy4", busy_vec, 32'h0000_0010);
      wb_valid = 1; wb_addr = 4; tick(); wb_valid = 0; #1;
      chk("t5_busy4_clr", busy_vec, 32'h0);

      // Sticky error, then async reset mid-DRAIN
      wb_valid = 1; wb_addr = 12;
      tick(); wb_valid = 0; #1;
      chk("t6_err_set", {31'b0, sb_err}, 32'h1);
      tick(); tick(); #1;
      chk("t6_err_sticky", {31'b0, sb_err}, 32'h1);
      wr(6); tick(); idle();
      flush_req = 1; tick(); flush_req = 0;
      wr(8); #1;
      chk("t6_in_drain", {31'b0, id_stall}, 32'h1);
      #1 rst_n = 0; #1;
      chk("t6_rst_err", {31'b0, sb_err}, 32'h0);
      chk("t6_rst_busy", busy_vec, 32'h0);
      chk("t6_rst_fdone", {31'b0, flush_done}, 32'h0);
      chk("t6_rst_run", {31'b0, id_stall}, 32'h0);
      tick(); rst_n = 1; #1;
      chk("t6_post_issue", {31'b0, id_issue}, 32'h1);
      tick(); idle(); #1;
      chk("t6_post_busy8", busy_vec, 32'h0000_0100);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got %0d expected %0d", n_chk, 0);
      $fatal(1);
   end

endmodule
